// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw keys/switches in, conditioned levels,
// pulses and synchronized switch data out.
interface button_conditioner_if;
  logic [2:0] key_n;      // raw active-low buttons: [2]=Execute, [1]=LoadA, [0]=LoadB
  logic [7:0] din;        // raw switch data
  logic [2:0] btn_sh;     // debounced active-high levels
  logic [2:0] press_p;    // one-cycle press pulses
  logic [2:0] release_p;  // one-cycle release pulses
  logic [7:0] din_s;      // switch data after two-flop synchronizer

  // Environment side: drives raw inputs, observes conditioned outputs.
  modport master (
    output key_n,
    output din,
    input  btn_sh,
    input  press_p,
    input  release_p,
    input  din_s
  );

  // Conditioner side: consumes raw inputs, produces conditioned outputs.
  modport slave (
    input  key_n,
    input  din,
    output btn_sh,
    output press_p,
    output release_p,
    output din_s
  );
endinterface

// File: rtl/button_conditioner.sv
// Button conditioner: synchronizes three active-low push buttons, debounces
// each with an independent four-state FSM, produces registered level and
// one-cycle press/release pulses with optional auto-repeat, and passes the
// switch data through a plain two-flop synchronizer.
module button_conditioner #(
  parameter int unsigned DB_CYCLES     = 16,
  parameter int unsigned REPEAT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  button_conditioner_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } btn_state_t;

  // Last count value before a pending change is accepted.
  localparam logic [15:0] DB_LAST  = 16'(DB_CYCLES - 1);
  // Repeat counter wrap value; only meaningful when auto-repeat is enabled.
  localparam logic [15:0] RPT_LAST = 16'(REPEAT_CYCLES - 1);
  localparam bit          RPT_EN   = (REPEAT_CYCLES != 0);

  logic [2:0]  key_sync1_q, key_sync1_d;
  logic [2:0]  key_sync2_q, key_sync2_d;   // s: 1 = pressed
  logic [7:0]  din_sync1_q, din_sync1_d;
  logic [7:0]  din_s_q,     din_s_d;

  btn_state_t  state_q [3];
  btn_state_t  state_d [3];
  logic [15:0] cnt_q   [3];
  logic [15:0] cnt_d   [3];
  logic [15:0] rpt_q   [3];
  logic [15:0] rpt_d   [3];

  logic [2:0]  btn_q,     btn_d;
  logic [2:0]  press_q,   press_d;
  logic [2:0]  release_q, release_d;

  // Synchronizer next values: keys are inverted on entry so s is active-high.
  always_comb begin
    key_sync1_d = ~bus.key_n;
    key_sync2_d = key_sync1_q;
    din_sync1_d = bus.din;
    din_s_d     = din_sync1_q;
  end

  // Per-channel debounce FSM, debounce counter and auto-repeat counter.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i]   = state_q[i];
      cnt_d[i]     = cnt_q[i];
      rpt_d[i]     = rpt_q[i];
      press_d[i]   = 1'b0;
      release_d[i] = 1'b0;

      case (state_q[i])
        ST_RELEASED: begin
          rpt_d[i] = 16'd0;
          if (key_sync2_q[i]) begin
            state_d[i] = ST_PRESS_PEND;
            cnt_d[i]   = 16'd1;
          end else begin
            cnt_d[i]   = 16'd0;
          end
        end

        ST_PRESS_PEND: begin
          if (!key_sync2_q[i]) begin
            // Any disagreeing sample throws away all progress.
            state_d[i] = ST_RELEASED;
            cnt_d[i]   = 16'd0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = 16'd0;
            rpt_d[i]   = 16'd0;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i]   = cnt_q[i] + 16'd1;
          end
        end

        ST_PRESSED: begin
          if (!key_sync2_q[i]) begin
            // Repeat counter is frozen while the release is being qualified.
            state_d[i] = ST_RELEASE_PEND;
            cnt_d[i]   = 16'd1;
          end else if (RPT_EN && (rpt_q[i] == RPT_LAST)) begin
            press_d[i] = 1'b1;
            rpt_d[i]   = 16'd0;
          end else if (RPT_EN) begin
            rpt_d[i]   = rpt_q[i] + 16'd1;
          end else begin
            rpt_d[i]   = 16'd0;
          end
        end

        ST_RELEASE_PEND: begin
          if (key_sync2_q[i]) begin
            // Release glitch: back to held without any pulse.
            state_d[i] = ST_PRESSED;
            cnt_d[i]   = 16'd0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i]   = ST_RELEASED;
            cnt_d[i]     = 16'd0;
            rpt_d[i]     = 16'd0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i]     = cnt_q[i] + 16'd1;
          end
        end

        default: begin
          state_d[i] = ST_RELEASED;
          cnt_d[i]   = 16'd0;
          rpt_d[i]   = 16'd0;
        end
      endcase

      // Level follows the next state so it moves on the same edge as the pulse.
      btn_d[i] = (state_d[i] == ST_PRESSED) || (state_d[i] == ST_RELEASE_PEND);
    end
  end

  // State, counter, synchronizer and output registers with async clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sync1_q <= 3'b000;
      key_sync2_q <= 3'b000;
      din_sync1_q <= 8'h00;
      din_s_q     <= 8'h00;
      btn_q       <= 3'b000;
      press_q     <= 3'b000;
      release_q   <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= ST_RELEASED;
        cnt_q[i]   <= 16'd0;
        rpt_q[i]   <= 16'd0;
      end
    end else begin
      key_sync1_q <= key_sync1_d;
      key_sync2_q <= key_sync2_d;
      din_sync1_q <= din_sync1_d;
      din_s_q     <= din_s_d;
      btn_q       <= btn_d;
      press_q     <= press_d;
      release_q   <= release_d;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        rpt_q[i]   <= rpt_d[i];
      end
    end
  end

  assign bus.btn_sh    = btn_q;
  assign bus.press_p   = press_q;
  assign bus.release_p = release_q;
  assign bus.din_s     = din_s_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// key/switch activity compared against a run-length debounce model.
module tb_button_conditioner;

  localparam int DB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  button_conditioner_if bus   ();
  button_conditioner_if bus_r ();

  button_conditioner #(.DB_CYCLES(DB), .REPEAT_CYCLES(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  button_conditioner #(.DB_CYCLES(DB), .REPEAT_CYCLES(50)) dut_r (
    .clk (clk),
    .rst (rst),
    .bus (bus_r)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: accepted level per channel plus the length of the
  // current run of synchronized samples that disagree with it.
  logic [2:0] m_sync1, m_s, m_lvl, m_press, m_release;
  int         m_run [3];
  logic [7:0] m_d1, m_d2;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync1 = 3'b000; m_s = 3'b000; m_lvl = 3'b000;
    m_press = 3'b000; m_release = 3'b000;
    m_d1 = 8'h00; m_d2 = 8'h00;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    m_press = 3'b000;
    m_release = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (m_s[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_lvl[i] = m_s[i];
          m_run[i] = 0;
          if (m_s[i]) m_press[i] = 1'b1;
          else        m_release[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s     = m_sync1;
    m_sync1 = ~bus.key_n;
    m_d2    = m_d1;
    m_d1    = bus.din;
  endtask

  // One clock edge: advance the model, then compare all outputs just after.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    chk("btn_sh",    {5'd0, bus.btn_sh},    {5'd0, m_lvl});
    chk("press_p",   {5'd0, bus.press_p},   {5'd0, m_press});
    chk("release_p", {5'd0, bus.release_p}, {5'd0, m_release});
    chk("din_s",     bus.din_s,             m_d2);
    chk("pulse_excl", {5'd0, bus.press_p & bus.release_p}, 8'h00);
  endtask

  task automatic drive(input logic [2:0] keys, input int n);
    bus.key_n = keys;
    for (int k = 0; k < n; k++) cycle();
  endtask

  initial begin
    int e;
    int pulses;
    bus.key_n   = 3'b111;
    bus.din     = 8'h00;
    bus_r.key_n = 3'b111;
    bus_r.din   = 8'h00;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_btn",   {5'd0, bus.btn_sh},    8'h00);
    chk("rst_press", {5'd0, bus.press_p},   8'h00);
    chk("rst_rel",   {5'd0, bus.release_p}, 8'h00);
    chk("rst_din",   bus.din_s,             8'h00);
    rst = 1'b0;
    drive(3'b111, 3);

    // Clean Execute press with Din change; edge numbering starts at 0.
    bus.key_n = 3'b011;
    bus.din   = 8'hA5;
    for (e = 0; e < 20; e++) begin
      cycle();
      if (e == 1)  chk("din_lat",    bus.din_s,                8'hA5);
      if (e == 16) chk("press_early",{5'd0, bus.btn_sh},       8'h00);
      if (e == 17) chk("press_lat",  {5'd0, bus.press_p},      8'h04);
      if (e == 17) chk("btn_lat",    {5'd0, bus.btn_sh},       8'h04);
      if (e == 18) chk("press_one",  {5'd0, bus.press_p},      8'h00);
    end
    drive(3'b111, 20);

    // Bounce on LoadA, then LoadB press, release glitch, and release.
    drive(3'b101, 10);
    drive(3'b111, 1);
    drive(3'b101, 20);
    drive(3'b111, 20);
    drive(3'b110, 20);
    drive(3'b111, 5);
    drive(3'b110, 10);
    bus.key_n = 3'b111;
    for (e = 0; e < 20; e++) begin
      cycle();
      if (e == 17) chk("rel_lat", {5'd0, bus.release_p}, 8'h01);
      if (e == 17) chk("rel_btn", {5'd0, bus.btn_sh},    8'h00);
    end

    // Async reset while all buttons are held.
    drive(3'b000, 20);
    chk("all_held", {5'd0, bus.btn_sh}, 8'h07);
    #2 rst = 1'b1;
    #1;
    chk("arst_btn",   {5'd0, bus.btn_sh},    8'h00);
    chk("arst_press", {5'd0, bus.press_p},   8'h00);
    chk("arst_rel",   {5'd0, bus.release_p}, 8'h00);
    chk("arst_din",   bus.din_s,             8'h00);
    model_reset();
    #1 rst = 1'b0;
    for (e = 0; e < 20; e++) begin
      cycle();
      if (e == 17) chk("rearm_press", {5'd0, bus.press_p}, 8'h07);
    end
    drive(3'b111, 20);

    // Random key and switch activity, short glitches mixed with long holds.
    for (int seg = 0; seg < 80; seg++) begin
      bus.key_n = 3'($urandom);
      bus.din   = 8'($urandom);
      if ($urandom_range(0, 1) == 0) drive(bus.key_n, $urandom_range(1, 6));
      else                           drive(bus.key_n, $urandom_range(14, 40));
    end
    drive(3'b111, 20);

    // Auto-repeat instance: pulses at acceptance and every 50 cycles after.
    bus_r.key_n = 3'b110;
    pulses = 0;
    for (e = 0; e < 217; e++) begin
      @(posedge clk);
      #1;
      chk("rpt_press",
          {5'd0, bus_r.press_p},
          (e >= 17 && ((e - 17) % 50) == 0) ? 8'h01 : 8'h00);
      if (bus_r.press_p[0]) pulses++;
    end
    chk("rpt_count", 8'(pulses), 8'd4);
    chk("rpt_btn", {5'd0, bus_r.btn_sh}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 16: consecutive agreeing synchronized samples needed to accept a level change; legal range 2..65535.
REQ-002 Parameter REPEAT_CYCLES, default 0: auto-repeat period in cycles while a button is held; 0 disables auto-repeat; legal range 0 or 2..65535.
REQ-003 Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Key_N  input  3  raw active-low push buttons: [2]=Execute, [1]=LoadA, [0]=LoadB.
REQ-006 Din  input  8  raw switch data.
REQ-007 Btn_SH  output  3  debounced active-high button levels, registered.
REQ-008 Press_P  output  3  one-cycle active-high press pulses, registered.
REQ-009 Release_P  output  3  one-cycle active-high release pulses, registered.
REQ-010 Din_S  output  8  Din after a two-flop synchronizer.

Function
REQ-011 Each Key_N bit SHALL pass inverted through a two-flop synchronizer; s[i] is the second-flop output, 1 = pressed.
REQ-012 Each of the three channels SHALL run an independent FSM with states RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND, plus a 16-bit debounce counter cnt.
REQ-013 RELEASED: s=1 -> PRESS_PEND, cnt<=1; s=0 -> stay, cnt<=0.
REQ-014 PRESS_PEND: s=0 -> RELEASED, cnt<=0; s=1 and cnt==DB_CYCLES-1 -> PRESSED, cnt<=0, Press_P<=1; otherwise cnt<=cnt+1.
REQ-015 PRESSED: s=0 -> RELEASE_PEND, cnt<=1; s=1 -> stay.
REQ-016 RELEASE_PEND: s=1 -> PRESSED, cnt<=0, no pulse; s=0 and cnt==DB_CYCLES-1 -> RELEASED, cnt<=0, Release_P<=1; otherwise cnt<=cnt+1.
REQ-017 Btn_SH[i] SHALL be 1 exactly when channel i is in PRESSED or RELEASE_PEND.
REQ-018 Latency: if the raw key settles before rising edge 0, Btn_SH and the matching pulse SHALL change after edge DB_CYCLES+1 (edge 17 at default).
REQ-019 A single s sample disagreeing during a PEND state SHALL abort that PEND state; there is no partial credit.
REQ-020 Press_P and Release_P SHALL each be high for exactly one cycle per accepted transition; they are never high together on one channel.
REQ-021 Auto-repeat (REPEAT_CYCLES>0): a 16-bit repeat counter SHALL clear on entry to PRESSED and increment each cycle in PRESSED; at REPEAT_CYCLES-1 it SHALL raise Press_P for one cycle and clear.
REQ-022 The repeat counter SHALL hold its value in RELEASE_PEND and clear when the channel returns to RELEASED.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each produce their own pulses in the same cycle.
REQ-024 Din_S SHALL equal Din delayed by exactly two rising edges, with no debounce.

Reset
REQ-025 Reset=1 SHALL immediately, without waiting for a clock edge, force: every FSM to RELEASED; all counters to 0; synchronizer flops to 0 (released); Btn_SH, Press_P, Release_P, and Din_S to 0.
REQ-026 Reset asserted mid-PEND or mid-PRESSED SHALL discard that progress without a pulse; a key still held at deassertion SHALL be re-debounced from RELEASED and pulse after DB_CYCLES+2 edges.

Verification
REQ-027 Clean press, DB=16: Key_N[2] goes 0 before edge 0 and is held -> Btn_SH[2]=1 and Press_P[2]=1 after edge 17, Press_P[2]=0 after edge 18, other bits 0.
REQ-028 Bounce: Key_N[1] low 10 cycles, high 1 cycle, then low steadily -> no Press_P[1] during the first 10 cycles; a single pulse follows 16 consecutive pressed samples.
REQ-029 Release: from PRESSED, release Key_N[0] -> Release_P[0] one cycle and Btn_SH[0]=0 after edge 17; a 5-cycle release glitch produces neither a release nor a new press pulse.
REQ-030 Auto-repeat, REPEAT_CYCLES=50: hold 200 cycles after press acceptance -> Press_P pulses at accept, +50, +100, +150.
REQ-031 Async reset: assert Reset between edges while Btn_SH=3'b111 -> all outputs are 0 before the next edge; with keys held at deassertion, three Press_P pulses occur together after edge 17.
REQ-032 Din: Din changes 8'h00 -> 8'hA5 before edge 0 -> Din_S=8'hA5 after edge 1.
